// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: default panel geometry, pixel field order and
// the receiver state encoding.
package hub75_pkg;

    localparam int COLS   = 64;
    localparam int ADDR_W = 5;

    // One pixel word carries both scan halves: {b1,g1,r1,b0,g0,r0}
    localparam int PIX_W  = 6;
    localparam int PIX_R0 = 0;
    localparam int PIX_G0 = 1;
    localparam int PIX_B0 = 2;
    localparam int PIX_R1 = 3;
    localparam int PIX_G1 = 4;
    localparam int PIX_B1 = 5;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } hub75_state_t;

endpackage

// File: rtl/hub75_sync.sv
// Two-flop synchronizer with a third history flop for rise/fall detection.
// Each bit has its own reset value so idle levels produce no edge on release.
module hub75_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;

    // Synchronizer chain plus one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel receiver: oversamples the panel bus on osc25m, rebuilds each
// row from panel_clk falling edges and streams the latched row out as
// per-column pixel words with valid/ready handshaking.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int COLS   = hub75_pkg::COLS,
    parameter int ADDR_W = hub75_pkg::ADDR_W,
    parameter int ONW    = 16
) (
    input  logic                      osc25m,
    input  logic                      resetn,
    input  logic                      panel_r0,
    input  logic                      panel_g0,
    input  logic                      panel_b0,
    input  logic                      panel_r1,
    input  logic                      panel_g1,
    input  logic                      panel_b1,
    input  logic [ADDR_W-1:0]         panel_addr,
    input  logic                      panel_clk,
    input  logic                      panel_lat,
    input  logic                      panel_oe,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [ADDR_W-1:0]         pix_row,
    output logic [$clog2(COLS)-1:0]   pix_col,
    output logic [5:0]                pix_rgb,
    output logic                      row_strobe,
    output logic [ONW-1:0]            on_cycles,
    output logic                      err_len,
    output logic                      err_overrun
);

    localparam int CW  = $clog2(COLS);
    localparam int NW  = $clog2(2 * COLS);
    localparam int SRW = COLS * PIX_W;
    localparam int SW  = PIX_W + ADDR_W + 3;

    // Sync vector layout, LSB first: pixel bits, address, clk, lat, oe.
    // Idle levels: clk=0, lat=0, oe=1 (blanked), everything else 0.
    localparam logic [SW-1:0] SYNC_RST = {1'b1, {(SW - 1){1'b0}}};

    logic [PIX_W-1:0] pix_in;
    logic [SW-1:0]    s_q;
    logic [SW-1:0]    s_rise;
    logic [SW-1:0]    s_fall;

    logic [PIX_W-1:0]  data;
    logic [ADDR_W-1:0] addr;
    logic              pclk_fall;
    logic              row_ev;
    logic              oe_q;
    logic              unused_sync;

    hub75_state_t state_q;
    hub75_state_t state_d;

    logic [SRW-1:0]  sr;
    logic [SRW-1:0]  sr_next;
    logic [SRW-1:0]  hold;
    logic [NW-1:0]   col_cnt;
    logic [NW-1:0]   col_cnt_next;
    logic [ONW-1:0]  oe_cnt;

    logic load;
    logic overrun;
    logic accept;
    logic last_col;

    // Place the panel data pins into the shared pixel field order
    always_comb begin
        pix_in         = '0;
        pix_in[PIX_R0] = panel_r0;
        pix_in[PIX_G0] = panel_g0;
        pix_in[PIX_B0] = panel_b0;
        pix_in[PIX_R1] = panel_r1;
        pix_in[PIX_G1] = panel_g1;
        pix_in[PIX_B1] = panel_b1;
    end

    hub75_sync #(
        .W       (SW),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk   (osc25m),
        .rst_n (resetn),
        .d     ({panel_oe, panel_lat, panel_clk, panel_addr, pix_in}),
        .q     (s_q),
        .rise  (s_rise),
        .fall  (s_fall)
    );

    assign data      = s_q[PIX_W-1:0];
    assign addr      = s_q[PIX_W +: ADDR_W];
    assign pclk_fall = s_fall[SW-3];
    assign row_ev    = s_fall[SW-2];
    assign oe_q      = s_q[SW-1];

    // Edges and levels of the sync vector that the receiver never looks at
    assign unused_sync = ^{s_rise, s_fall[SW-1], s_fall[SW-4:0], s_q[SW-2:SW-3]};

    // Shift and column count as they stand after this cycle's panel_clk edge,
    // so a latch arriving with the final shift transfers and measures it too
    always_comb begin
        sr_next      = sr;
        col_cnt_next = col_cnt;
        if (pclk_fall) begin
            sr_next = {data, sr[SRW-1:PIX_W]};
            if (col_cnt != NW'(2 * COLS - 1)) begin
                col_cnt_next = col_cnt + 1'b1;
            end
        end
    end

    // Row shift register and falling-edge column counter
    always_ff @(posedge osc25m or negedge resetn) begin
        if (!resetn) begin
            sr      <= '0;
            col_cnt <= '0;
        end else begin
            sr      <= sr_next;
            col_cnt <= row_ev ? '0 : col_cnt_next;
        end
    end

    assign accept   = pix_valid && pix_ready;
    assign last_col = (pix_col == CW'(COLS - 1));

    // FSM state register
    always_ff @(posedge osc25m or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a latch in IDLE starts a stream, a latch while streaming is dropped
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        overrun = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (row_ev) begin
                    load    = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (row_ev) begin
                    overrun = 1'b1;
                end
                if (accept && last_col) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pix_valid = (state_q == ST_STREAM);

    // Hold register, row address and column pointer for the outgoing stream
    always_ff @(posedge osc25m or negedge resetn) begin
        if (!resetn) begin
            hold       <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            row_strobe <= 1'b0;
        end else begin
            row_strobe <= load;
            if (load) begin
                hold    <= sr_next;
                pix_row <= addr;
                pix_col <= '0;
            end else if (accept) begin
                pix_col <= last_col ? '0 : pix_col + 1'b1;
            end
        end
    end

    // Current column's pixel word from the held row
    always_comb begin
        pix_rgb = hold[int'(pix_col) * PIX_W +: PIX_W];
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge osc25m or negedge resetn) begin
        if (!resetn) begin
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (row_ev && (col_cnt_next != NW'(COLS))) begin
                err_len <= 1'b1;
            end
            if (overrun) begin
                err_overrun <= 1'b1;
            end
        end
    end

    // Output-enable on-time: count OE-low cycles, publish and restart at each latch
    always_ff @(posedge osc25m or negedge resetn) begin
        if (!resetn) begin
            oe_cnt    <= '0;
            on_cycles <= '0;
        end else if (row_ev) begin
            on_cycles <= oe_cnt;
            oe_cnt    <= '0;
        end else if (!oe_q && (oe_cnt != '1)) begin
            oe_cnt <= oe_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: drives panel rows slowly relative to osc25m,
// then consumes and checks the resulting pixel streams.
module tb_hub75_rx;

    logic        osc25m = 1'b0;
    logic        resetn = 1'b0;
    logic        panel_r0 = 1'b0, panel_g0 = 1'b0, panel_b0 = 1'b0;
    logic        panel_r1 = 1'b0, panel_g1 = 1'b0, panel_b1 = 1'b0;
    logic [4:0]  panel_addr = '0;
    logic        panel_clk = 1'b0;
    logic        panel_lat = 1'b0;
    logic        panel_oe  = 1'b1;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [4:0]  pix_row;
    logic [5:0]  pix_col;
    logic [5:0]  pix_rgb;
    logic        row_strobe;
    logic [15:0] on_cycles;
    logic        err_len;
    logic        err_overrun;

    int n_cmp = 0;
    int n_err = 0;

    hub75_rx #(
        .COLS   (64),
        .ADDR_W (5),
        .ONW    (16)
    ) dut (
        .osc25m      (osc25m),
        .resetn      (resetn),
        .panel_r0    (panel_r0),
        .panel_g0    (panel_g0),
        .panel_b0    (panel_b0),
        .panel_r1    (panel_r1),
        .panel_g1    (panel_g1),
        .panel_b1    (panel_b1),
        .panel_addr  (panel_addr),
        .panel_clk   (panel_clk),
        .panel_lat   (panel_lat),
        .panel_oe    (panel_oe),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .pix_rgb     (pix_rgb),
        .row_strobe  (row_strobe),
        .on_cycles   (on_cycles),
        .err_len     (err_len),
        .err_overrun (err_overrun)
    );

    always #20 osc25m = ~osc25m;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge osc25m);
    endtask

    // npix panel clocks; pixel n carries rgb = (n + base) mod 64
    task automatic send_row(input int npix, input int base);
        logic [5:0] v;
        for (int n = 0; n < npix; n++) begin
            v = 6'(n + base);
            {panel_b1, panel_g1, panel_r1, panel_b0, panel_g0, panel_r0} = v;
            panel_clk = 1'b1;
            cyc(3);
            panel_clk = 1'b0;
            cyc(3);
        end
    endtask

    task automatic latch_row(input int addr, input int exp_strobes);
        int seen;
        seen = 0;
        panel_addr = 5'(addr);
        cyc(2);
        panel_lat = 1'b1;
        cyc(3);
        panel_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (row_strobe) seen++;
        end
        chk("row_strobe_count", seen, exp_strobes);
    endtask

    // Consume one 64-word stream; column k must carry rgb = (k + base) mod 64
    task automatic recv_row(input int row, input int base, input int stall_col, input int stall_len);
        int waited;
        logic [5:0] e_rgb;
        waited = 0;
        while (!pix_valid && waited < 100) begin
            cyc(1);
            waited++;
        end
        chk("stream_start", pix_valid, 1);
        for (int k = 0; k < 64; k++) begin
            e_rgb = 6'(k + base);
            chk("word_valid", pix_valid, 1);
            chk("word_col", pix_col, k);
            chk("word_rgb", pix_rgb, e_rgb);
            chk("word_row", pix_row, row);
            if (k == stall_col) begin
                pix_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    cyc(1);
                    chk("stall_valid", pix_valid, 1);
                    chk("stall_col", pix_col, k);
                    chk("stall_rgb", pix_rgb, e_rgb);
                end
            end
            pix_ready = 1'b1;
            cyc(1);
        end
        pix_ready = 1'b0;
        chk("valid_after_row", pix_valid, 0);
    endtask

    initial begin
        int seen;
        int i;

        // Reset values
        cyc(3);
        chk("rst_valid", pix_valid, 0);
        chk("rst_row", pix_row, 0);
        chk("rst_col", pix_col, 0);
        chk("rst_rgb", pix_rgb, 0);
        chk("rst_strobe", row_strobe, 0);
        chk("rst_on_cycles", on_cycles, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_overrun", err_overrun, 0);
        resetn = 1'b1;
        cyc(5);
        chk("idle_valid", pix_valid, 0);

        // Full row, address 7
        send_row(64, 0);
        latch_row(7, 1);
        chk("good_err_len", err_len, 0);
        recv_row(7, 0, -1, 0);
        chk("good_err_overrun", err_overrun, 0);
        chk("good_on_cycles", on_cycles, 0);

        // Backpressure on column 5 for 10 cycles
        send_row(64, 0);
        latch_row(2, 1);
        recv_row(2, 0, 5, 10);

        // Short row: 63 clocks; column 0 keeps the previous row's column 63
        send_row(63, 0);
        latch_row(3, 1);
        chk("short_err_len", err_len, 1);
        recv_row(3, 63, -1, 0);
        send_row(64, 0);
        latch_row(4, 1);
        recv_row(4, 0, -1, 0);
        chk("err_len_sticky", err_len, 1);

        // Overrun: second latch while the first stream is stalled
        send_row(64, 10);
        latch_row(9, 1);
        cyc(4);
        chk("ovr_stalled_valid", pix_valid, 1);
        panel_oe = 1'b0;
        cyc(100);
        panel_oe = 1'b1;
        cyc(4);
        send_row(64, 40);
        latch_row(12, 0);
        chk("ovr_err_overrun", err_overrun, 1);
        chk_range("ovr_on_cycles", int'(on_cycles), 98, 102);
        chk("ovr_col_untouched", pix_col, 0);
        chk("ovr_row_untouched", pix_row, 9);
        recv_row(9, 10, -1, 0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1);
            if (pix_valid) seen++;
        end
        chk("ovr_second_row_absent", seen, 0);

        // On-time: OE low for 200 cycles between latches
        panel_oe = 1'b0;
        cyc(200);
        panel_oe = 1'b1;
        cyc(4);
        send_row(64, 20);
        latch_row(6, 1);
        chk_range("on_cycles_200", int'(on_cycles), 198, 202);
        recv_row(6, 20, -1, 0);

        // Reset in the middle of a stream at column 30
        send_row(64, 0);
        latch_row(1, 1);
        pix_ready = 1'b1;
        i = 0;
        while (!(pix_valid && pix_col == 6'd30) && i < 200) begin
            cyc(1);
            i++;
        end
        chk("mid_col_reached", pix_col, 30);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_col", pix_col, 0);
        chk("mid_rst_rgb", pix_rgb, 0);
        chk("mid_rst_err_len", err_len, 0);
        chk("mid_rst_err_overrun", err_overrun, 0);
        chk("mid_rst_on_cycles", on_cycles, 0);
        cyc(3);
        resetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            cyc(1);
            if (pix_valid) seen++;
        end
        chk("post_rst_no_word", seen, 0);
        pix_ready = 1'b0;
        send_row(64, 5);
        latch_row(8, 1);
        chk("post_rst_err_len", err_len, 0);
        recv_row(8, 5, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
